// File: rtl/iob_sched.sv
// IOB transfer scheduler: turns CPU I/O bus cycles into a 4-phase IOREQ/IOACK
// handshake, with posted-write early termination and a QoS hold-off window.
module iob_sched #(
  parameter logic [7:0] QOS_HOLD = 8'd64
) (
  input  logic CLK,
  input  logic nRES,
  input  logic BACT,
  input  logic IOCS,
  input  logic IOPWCS,
  input  logic IOACK,
  output logic IOREQ,
  output logic IOPW,
  output logic LatchEN,
  output logic IORDY,
  output logic QoSEN,
  output logic IOBusy
);

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_REQ  = 2'd1,
    E_REL  = 2'd2
  } eng_t;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WAIT = 2'd1,
    C_XFER = 2'd2,
    C_DONE = 2'd3
  } cpu_t;

  eng_t       eng_q, eng_d;
  cpu_t       cpu_q, cpu_d;
  logic [7:0] qos_q, qos_d;
  logic       bact_prev_q, bact_prev_d;
  logic       pw_lat_q, pw_lat_d;
  logic       iopw_q, iopw_d;
  logic       latch_en_q, latch_en_d;
  logic       iordy_q, iordy_d;

  logic       start_s;
  logic       grant_s;
  logic       grant_pw_s;
  logic       qos_load_s;

  // State register; reset parks the engine in E_REL so a live IOACK is drained first
  always_ff @(posedge CLK) begin
    if (!nRES) begin
      eng_q       <= E_REL;
      cpu_q       <= C_IDLE;
      qos_q       <= 8'd0;
      bact_prev_q <= 1'b0;
      pw_lat_q    <= 1'b0;
      iopw_q      <= 1'b0;
      latch_en_q  <= 1'b0;
      iordy_q     <= 1'b0;
    end else begin
      eng_q       <= eng_d;
      cpu_q       <= cpu_d;
      qos_q       <= qos_d;
      bact_prev_q <= bact_prev_d;
      pw_lat_q    <= pw_lat_d;
      iopw_q      <= iopw_d;
      latch_en_q  <= latch_en_d;
      iordy_q     <= iordy_d;
    end
  end

  // CPU-side FSM: start detection, grant arbitration against the engine, termination pulses
  always_comb begin
    cpu_d       = cpu_q;
    pw_lat_d    = pw_lat_q;
    latch_en_d  = 1'b0;
    iordy_d     = 1'b0;
    grant_s     = 1'b0;
    grant_pw_s  = 1'b0;
    qos_load_s  = 1'b0;
    bact_prev_d = BACT;
    start_s     = BACT & ~bact_prev_q;

    case (cpu_q)
      C_IDLE: begin
        if (start_s && IOCS) begin
          pw_lat_d = IOPWCS;
          if (eng_q == E_IDLE) begin
            grant_s    = 1'b1;
            grant_pw_s = IOPWCS;
          end else begin
            cpu_d      = C_WAIT;
            qos_load_s = IOPWCS;
          end
        end else begin
          cpu_d = C_IDLE;
        end
      end
      C_WAIT: begin
        if (!BACT) begin
          cpu_d = C_IDLE;
        end else if (eng_q == E_IDLE) begin
          grant_s    = 1'b1;
          grant_pw_s = pw_lat_q;
        end else begin
          cpu_d = C_WAIT;
        end
      end
      C_XFER: begin
        // E_REL while we own the engine means our request was just acknowledged
        if (!BACT) begin
          cpu_d = C_IDLE;
        end else if (eng_q == E_REL) begin
          iordy_d = 1'b1;
          cpu_d   = C_DONE;
        end else begin
          cpu_d = C_XFER;
        end
      end
      C_DONE: begin
        if (!BACT) begin
          cpu_d = C_IDLE;
        end else begin
          cpu_d = C_DONE;
        end
      end
      default: begin
        cpu_d = C_IDLE;
      end
    endcase

    if (grant_s) begin
      cpu_d      = grant_pw_s ? C_DONE : C_XFER;
      latch_en_d = grant_pw_s;
      iordy_d    = grant_pw_s;
    end else begin
      latch_en_d = 1'b0;
    end
  end

  // Engine FSM, posted-write flag and QoS countdown
  always_comb begin
    eng_d  = eng_q;
    iopw_d = iopw_q;
    qos_d  = qos_q;

    case (eng_q)
      E_IDLE: eng_d = grant_s ? E_REQ : E_IDLE;
      E_REQ:  eng_d = IOACK ? E_REL : E_REQ;
      E_REL:  eng_d = IOACK ? E_REL : E_IDLE;
      default: eng_d = E_REL;
    endcase

    if (grant_s) begin
      iopw_d = grant_pw_s;
    end else if (eng_d == E_IDLE) begin
      iopw_d = 1'b0;
    end else begin
      iopw_d = iopw_q;
    end

    // Countdown is frozen while a request is still waiting for the engine
    if (qos_load_s) begin
      qos_d = QOS_HOLD;
    end else if ((qos_q != 8'd0) && (cpu_q != C_WAIT)) begin
      qos_d = qos_q - 8'd1;
    end else begin
      qos_d = qos_q;
    end
  end

  assign IOREQ   = (eng_q == E_REQ);
  assign IOBusy  = (eng_q != E_IDLE);
  assign IOPW    = iopw_q;
  assign LatchEN = latch_en_q;
  assign IORDY   = iordy_q;
  assign QoSEN   = (qos_q != 8'd0);

endmodule

// File: tb/tb_iob_sched.sv
// Directed testbench for iob_sched: cycle-indexed scenarios with hand-computed expectations.
module tb_iob_sched;

  logic CLK;
  logic nRES;
  logic BACT;
  logic IOCS;
  logic IOPWCS;
  logic IOACK;
  logic IOREQ;
  logic IOPW;
  logic LatchEN;
  logic IORDY;
  logic QoSEN;
  logic IOBusy;

  int checks;
  int failures;

  // Mid-cycle activity monitor
  int   latch_cnt;
  int   iordy_cnt;
  int   ioreq_rise;
  int   dbl_cnt;
  logic latch_prev;
  logic iordy_prev;
  logic ioreq_prev;

  int latch_base;
  int iordy_base;
  int rise_base;

  iob_sched #(.QOS_HOLD(8'd64)) dut (
    .CLK    (CLK),
    .nRES   (nRES),
    .BACT   (BACT),
    .IOCS   (IOCS),
    .IOPWCS (IOPWCS),
    .IOACK  (IOACK),
    .IOREQ  (IOREQ),
    .IOPW   (IOPW),
    .LatchEN(LatchEN),
    .IORDY  (IORDY),
    .QoSEN  (QoSEN),
    .IOBusy (IOBusy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    latch_cnt  = 0;
    iordy_cnt  = 0;
    ioreq_rise = 0;
    dbl_cnt    = 0;
    latch_prev = 1'b0;
    iordy_prev = 1'b0;
    ioreq_prev = 1'b0;
  end

  always @(negedge CLK) begin
    if (LatchEN === 1'b1) latch_cnt = latch_cnt + 1;
    if (IORDY === 1'b1) iordy_cnt = iordy_cnt + 1;
    if ((IOREQ === 1'b1) && (ioreq_prev !== 1'b1)) ioreq_rise = ioreq_rise + 1;
    if (((LatchEN === 1'b1) && (latch_prev === 1'b1)) || ((IORDY === 1'b1) && (iordy_prev === 1'b1)))
      dbl_cnt = dbl_cnt + 1;
    latch_prev = LatchEN;
    iordy_prev = IORDY;
    ioreq_prev = IOREQ;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    nRES = 1'b0; BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0; IOACK = 1'b1;
    ticks(2);
    checks++; if (IOREQ !== 1'b0) begin failures++; $display("FAIL rst_ioreq act=%b exp=0", IOREQ); end
    checks++; if (IOPW !== 1'b0) begin failures++; $display("FAIL rst_iopw act=%b exp=0", IOPW); end
    checks++; if (LatchEN !== 1'b0) begin failures++; $display("FAIL rst_latchen act=%b exp=0", LatchEN); end
    checks++; if (IORDY !== 1'b0) begin failures++; $display("FAIL rst_iordy act=%b exp=0", IORDY); end
    checks++; if (QoSEN !== 1'b0) begin failures++; $display("FAIL rst_qosen act=%b exp=0", QoSEN); end
    checks++; if (IOBusy !== 1'b1) begin failures++; $display("FAIL rst_iobusy act=%b exp=1", IOBusy); end
    nRES = 1'b1;
    tick();
    checks++; if (IOBusy !== 1'b1) begin failures++; $display("FAIL rst_busy_ackhi act=%b exp=1", IOBusy); end
    IOACK = 1'b0;
    tick();
    checks++; if (IOBusy !== 1'b0) begin failures++; $display("FAIL rst_busy_acklo act=%b exp=0", IOBusy); end
  endtask

  task automatic test_posted();
    BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b1;
    checks++; if (IOREQ !== 1'b0) begin failures++; $display("FAIL pw_ioreq_c0 act=%b exp=0", IOREQ); end
    tick();
    checks++; if (LatchEN !== 1'b1) begin failures++; $display("FAIL pw_latchen_c1 act=%b exp=1", LatchEN); end
    checks++; if (IORDY !== 1'b1) begin failures++; $display("FAIL pw_iordy_c1 act=%b exp=1", IORDY); end
    checks++; if (IOREQ !== 1'b1) begin failures++; $display("FAIL pw_ioreq_c1 act=%b exp=1", IOREQ); end
    checks++; if (IOPW !== 1'b1) begin failures++; $display("FAIL pw_iopw_c1 act=%b exp=1", IOPW); end
    BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0;
    tick();
    checks++; if (IORDY !== 1'b0) begin failures++; $display("FAIL pw_iordy_c2 act=%b exp=0", IORDY); end
    ticks(2);
    IOACK = 1'b1;
    tick();
    checks++; if (IOREQ !== 1'b0) begin failures++; $display("FAIL pw_ioreq_c5 act=%b exp=0", IOREQ); end
    checks++; if (IOPW !== 1'b1) begin failures++; $display("FAIL pw_iopw_c5 act=%b exp=1", IOPW); end
    IOACK = 1'b0;
    tick();
    checks++; if (IOBusy !== 1'b0) begin failures++; $display("FAIL pw_iobusy_c6 act=%b exp=0", IOBusy); end
    checks++; if (IOPW !== 1'b0) begin failures++; $display("FAIL pw_iopw_c6 act=%b exp=0", IOPW); end
  endtask

  task automatic test_nonposted();
    latch_base = latch_cnt;
    BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b0;
    tick();
    checks++; if (IOREQ !== 1'b1) begin failures++; $display("FAIL np_ioreq_c1 act=%b exp=1", IOREQ); end
    checks++; if (IOPW !== 1'b0) begin failures++; $display("FAIL np_iopw_c1 act=%b exp=0", IOPW); end
    checks++; if (IORDY !== 1'b0) begin failures++; $display("FAIL np_iordy_c1 act=%b exp=0", IORDY); end
    ticks(5);
    IOACK = 1'b1;
    tick();
    checks++; if (IORDY !== 1'b0) begin failures++; $display("FAIL np_iordy_c7 act=%b exp=0", IORDY); end
    checks++; if (IOREQ !== 1'b0) begin failures++; $display("FAIL np_ioreq_c7 act=%b exp=0", IOREQ); end
    tick();
    checks++; if (IORDY !== 1'b1) begin failures++; $display("FAIL np_iordy_c8 act=%b exp=1", IORDY); end
    IOACK = 1'b0; BACT = 1'b0; IOCS = 1'b0;
    tick();
    checks++; if (IORDY !== 1'b0) begin failures++; $display("FAIL np_iordy_c9 act=%b exp=0", IORDY); end
    checks++; if (IOBusy !== 1'b0) begin failures++; $display("FAIL np_iobusy_c9 act=%b exp=0", IOBusy); end
    checks++; if (latch_cnt - latch_base !== 0) begin failures++; $display("FAIL np_latch_count act=%0d exp=0", latch_cnt - latch_base); end
  endtask

  task automatic test_no_iocs();
    latch_base = latch_cnt; iordy_base = iordy_cnt;
    BACT = 1'b1; IOCS = 1'b0; IOPWCS = 1'b0;
    ticks(3);
    checks++; if (IOBusy !== 1'b0) begin failures++; $display("FAIL noio_iobusy act=%b exp=0", IOBusy); end
    checks++; if ((latch_cnt - latch_base) + (iordy_cnt - iordy_base) !== 0)
      begin failures++; $display("FAIL noio_pulses act=%0d exp=0", (latch_cnt - latch_base) + (iordy_cnt - iordy_base)); end
    BACT = 1'b0;
    tick();
  endtask

  task automatic test_xfer_abort();
    BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b0;
    tick();
    checks++; if (IOREQ !== 1'b1) begin failures++; $display("FAIL xab_ioreq_c1 act=%b exp=1", IOREQ); end
    iordy_base = iordy_cnt;
    BACT = 1'b0; IOCS = 1'b0;
    tick();
    IOACK = 1'b1;
    tick();
    checks++; if (IOREQ !== 1'b0) begin failures++; $display("FAIL xab_ioreq_c3 act=%b exp=0", IOREQ); end
    IOACK = 1'b0;
    ticks(2);
    checks++; if (iordy_cnt - iordy_base !== 0) begin failures++; $display("FAIL xab_iordy_count act=%0d exp=0", iordy_cnt - iordy_base); end
    checks++; if (IOBusy !== 1'b0) begin failures++; $display("FAIL xab_iobusy act=%b exp=0", IOBusy); end
  endtask

  task automatic test_back_to_back();
    BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b1;
    tick();
    checks++; if (IORDY !== 1'b1) begin failures++; $display("FAIL b2b_a_iordy act=%b exp=1", IORDY); end
    BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0;
    tick();
    iordy_base = iordy_cnt;
    BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b1;
    tick();
    checks++; if (QoSEN !== 1'b1) begin failures++; $display("FAIL b2b_qosen_c3 act=%b exp=1", QoSEN); end
    IOACK = 1'b1;
    tick();
    IOACK = 1'b0;
    tick();
    checks++; if (IOREQ !== 1'b0) begin failures++; $display("FAIL b2b_ioreq_c5 act=%b exp=0", IOREQ); end
    checks++; if (iordy_cnt - iordy_base !== 0) begin failures++; $display("FAIL b2b_iordy_early act=%0d exp=0", iordy_cnt - iordy_base); end
    tick();
    checks++; if (IORDY !== 1'b1) begin failures++; $display("FAIL b2b_b_iordy_c6 act=%b exp=1", IORDY); end
    checks++; if (LatchEN !== 1'b1) begin failures++; $display("FAIL b2b_b_latchen_c6 act=%b exp=1", LatchEN); end
    checks++; if (IOREQ !== 1'b1) begin failures++; $display("FAIL b2b_b_ioreq_c6 act=%b exp=1", IOREQ); end
    BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0;
    tick();
    IOACK = 1'b1;
    tick();
    IOACK = 1'b0;
    tick();
    ticks(60);
    checks++; if (QoSEN !== 1'b1) begin failures++; $display("FAIL b2b_qosen_c69 act=%b exp=1", QoSEN); end
    tick();
    checks++; if (QoSEN !== 1'b0) begin failures++; $display("FAIL b2b_qosen_c70 act=%b exp=0", QoSEN); end
  endtask

  task automatic test_abort();
    BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b1;
    tick();
    BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0;
    tick();
    latch_base = latch_cnt; iordy_base = iordy_cnt;
    BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b1;
    tick();
    checks++; if (QoSEN !== 1'b1) begin failures++; $display("FAIL abt_qosen act=%b exp=1", QoSEN); end
    tick();
    BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0;
    tick();
    rise_base = ioreq_rise;
    IOACK = 1'b1;
    tick();
    IOACK = 1'b0;
    ticks(5);
    checks++; if (latch_cnt - latch_base !== 0) begin failures++; $display("FAIL abt_latch act=%0d exp=0", latch_cnt - latch_base); end
    checks++; if (iordy_cnt - iordy_base !== 0) begin failures++; $display("FAIL abt_iordy act=%0d exp=0", iordy_cnt - iordy_base); end
    checks++; if (ioreq_rise - rise_base !== 0) begin failures++; $display("FAIL abt_ioreq_rise act=%0d exp=0", ioreq_rise - rise_base); end
    checks++; if (IOBusy !== 1'b0) begin failures++; $display("FAIL abt_iobusy act=%b exp=0", IOBusy); end
  endtask

  task automatic test_reset_mid();
    BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b0;
    tick();
    checks++; if (IOREQ !== 1'b1) begin failures++; $display("FAIL rm_ioreq_c1 act=%b exp=1", IOREQ); end
    nRES = 1'b0; IOACK = 1'b1; BACT = 1'b0;
    tick();
    checks++; if (IOREQ !== 1'b0) begin failures++; $display("FAIL rm_ioreq_c2 act=%b exp=0", IOREQ); end
    checks++; if (IOBusy !== 1'b1) begin failures++; $display("FAIL rm_iobusy_c2 act=%b exp=1", IOBusy); end
    checks++; if (QoSEN !== 1'b0) begin failures++; $display("FAIL rm_qosen_c2 act=%b exp=0", QoSEN); end
    nRES = 1'b1; BACT = 1'b1; IOCS = 1'b1;
    ticks(2);
    checks++; if (IOREQ !== 1'b0) begin failures++; $display("FAIL rm_ioreq_c4 act=%b exp=0", IOREQ); end
    checks++; if (IOBusy !== 1'b1) begin failures++; $display("FAIL rm_iobusy_c4 act=%b exp=1", IOBusy); end
    IOACK = 1'b0;
    tick();
    checks++; if (IOREQ !== 1'b0) begin failures++; $display("FAIL rm_ioreq_c5 act=%b exp=0", IOREQ); end
    checks++; if (IOBusy !== 1'b0) begin failures++; $display("FAIL rm_iobusy_c5 act=%b exp=0", IOBusy); end
    tick();
    checks++; if (IOREQ !== 1'b1) begin failures++; $display("FAIL rm_ioreq_c6 act=%b exp=1", IOREQ); end
    checks++; if (IOPW !== 1'b0) begin failures++; $display("FAIL rm_iopw_c6 act=%b exp=0", IOPW); end
    IOACK = 1'b1;
    ticks(2);
    checks++; if (IORDY !== 1'b1) begin failures++; $display("FAIL rm_iordy_c8 act=%b exp=1", IORDY); end
    IOACK = 1'b0; BACT = 1'b0; IOCS = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRES = 1'b0; BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0; IOACK = 1'b0;
    tick();
    test_reset();
    test_posted();
    test_nonposted();
    test_no_iocs();
    test_xfer_abort();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    checks++; if (dbl_cnt !== 0) begin failures++; $display("FAIL pulse_width act=%0d exp=0", dbl_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
